// File: rtl/tag_dispatch.sv
// Dispatch stage: allocates a rename tag per decoded instruction into a one-entry output register, recycles tags from the CDB.
// Decoder-to-launch latency is 1 cycle; the decoder stalls when no tag is free or the held instruction cannot launch.
module tag_dispatch #(
  parameter int TAG_W    = 4,
  parameter int NUM_TAGS = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  output logic             dec_ready,
  input  logic             ds_ready,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [TAG_W-1:0] rd_tag,
  output logic             inst_valid,
  input  logic             cdb_active,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic [TAG_W-1:0] free_cnt,
  output logic             err_dbl_free
);

  localparam logic [TAG_W-1:0] CNT_ALL = TAG_W'(NUM_TAGS);
  localparam logic [TAG_W-1:0] CNT_ONE = TAG_W'(1);

  logic [NUM_TAGS:1]  free_mask;
  logic [NUM_TAGS:1]  mask_nxt;
  logic [TAG_W-1:0]   cnt_nxt;
  logic [TAG_W-1:0]   alloc_tag;
  logic               out_valid;
  logic               any_free;
  logic               accept;
  logic               launch;
  logic               cdb_in_range;
  logic               free_ok;
  logic               dup_free;

  // Lowest-numbered free tag wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (free_mask[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign any_free     = |free_mask;
  assign dec_ready    = rst_in & rdy_in & ~flush_in & any_free & (~out_valid | ds_ready);
  assign accept       = dec_valid & dec_ready;
  assign launch       = rst_in & rdy_in & ~flush_in & out_valid & ds_ready;
  assign inst_valid   = launch;

  assign cdb_in_range = (cdb_tag != '0) && (int'(cdb_tag) <= NUM_TAGS);
  assign dup_free     = cdb_active && cdb_in_range && free_mask[cdb_tag];
  assign free_ok      = cdb_active && cdb_in_range && !free_mask[cdb_tag];

  // Free decisions use the registered mask, so a tag freed this cycle is never handed out this cycle.
  always_comb begin
    mask_nxt = free_mask;
    cnt_nxt  = free_cnt;
    if (accept) begin
      mask_nxt[alloc_tag] = 1'b0;
      cnt_nxt             = cnt_nxt - CNT_ONE;
    end
    if (free_ok) begin
      mask_nxt[cdb_tag] = 1'b1;
      cnt_nxt           = cnt_nxt + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      free_mask    <= '1;
      free_cnt     <= CNT_ALL;
      out_valid    <= 1'b0;
      rd           <= '0;
      rs1          <= '0;
      rs2          <= '0;
      rd_tag       <= '0;
      err_dbl_free <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        free_mask <= '1;
        free_cnt  <= CNT_ALL;
        out_valid <= 1'b0;
      end else begin
        free_mask <= mask_nxt;
        free_cnt  <= cnt_nxt;
        if (dup_free) err_dbl_free <= 1'b1;
        if (accept) begin
          out_valid <= 1'b1;
          rd        <= dec_rd;
          rs1       <= dec_rs1;
          rs2       <= dec_rs2;
          rd_tag    <= alloc_tag;
        end else if (launch) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
